// File: rtl/mux_4to1.sv
`default_nettype none
// ============================================================================
//  Module      : mux_4to1
//  Description : Four-lane, one-output selector with a 2-bit select.
//                Provides a zero-latency combinational output (Y), a one-hot
//                decode of the select, and a one-cycle registered copy of the
//                selected lane with a valid flag.
//
//  Parameters  : WIDTH       - bit width of each input lane and of the outputs
//
//  Ports       : clk         - rising-edge clock for the registered path
//                rst_n       - asynchronous, active-low reset (registered path)
//                I           - packed lanes, lane k at I[k*WIDTH +: WIDTH]
//                S           - lane select, value k chooses lane k
//                in_valid    - qualifies I/S for capture into the register
//                Y           - combinational selected lane
//                sel_onehot  - combinational one-hot decode of S
//                y_reg       - registered selected lane (held when !in_valid)
//                y_valid     - registered in_valid
//                y_parity    - XOR-reduction of the captured lane
//                              (present only with MUX_4TO1_PARITY_EN)
//
//  Build option: `define MUX_4TO1_PARITY_EN adds the y_parity output.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_4to1 #(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [4*WIDTH-1:0] I,
    input  logic [1:0]         S,
    input  logic               in_valid,
    output logic [WIDTH-1:0]   Y,
    output logic [3:0]         sel_onehot,
    output logic [WIDTH-1:0]   y_reg,
    output logic               y_valid
`ifdef MUX_4TO1_PARITY_EN
    ,
    output logic               y_parity
`endif
);

    localparam logic [3:0] c_ONEHOT_BASE = 4'b0001;

    // ------------------------------------------------------------------------
    // Unpack the flat lane bus into an array for readable selection.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_lane [4];

    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_lane
            assign w_lane[k] = I[k*WIDTH +: WIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Combinational path: stays live during reset.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_y;

    always_comb begin
        w_y = w_lane[0];
        case (S)
            2'b00:   w_y = w_lane[0];
            2'b01:   w_y = w_lane[1];
            2'b10:   w_y = w_lane[2];
            2'b11:   w_y = w_lane[3];
            default: w_y = w_lane[0];
        endcase
    end

    assign Y          = w_y;
    assign sel_onehot = c_ONEHOT_BASE << S;

    // ------------------------------------------------------------------------
    // Registered path. y_reg only loads on a qualified cycle, while y_valid
    // simply mirrors in_valid one cycle late.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] r_y;
    logic             r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_y <= w_y;
            end
        end
    end

    assign y_reg   = r_y;
    assign y_valid = r_valid;

`ifdef MUX_4TO1_PARITY_EN
    // Parity is computed from the lane being captured, so it always matches
    // the value held in y_reg.
    logic r_parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (in_valid) begin
            r_parity <= ^w_y;
        end
    end

    assign y_parity = r_parity;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_4to1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_4to1
//  Description : Self-checking bench for mux_4to1 (WIDTH=1). Table-driven
//                combinational vectors followed by hand-written sequences for
//                capture, hold and asynchronous reset behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_4to1;

    localparam int WIDTH = 1;

    logic             clk;
    logic             rst_n;
    logic [4*WIDTH-1:0] I;
    logic [1:0]       S;
    logic             in_valid;
    logic [WIDTH-1:0] Y;
    logic [3:0]       sel_onehot;
    logic [WIDTH-1:0] y_reg;
    logic             y_valid;
`ifdef MUX_4TO1_PARITY_EN
    logic             y_parity;
`endif

    mux_4to1 #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .I          (I),
        .S          (S),
        .in_valid   (in_valid),
        .Y          (Y),
        .sel_onehot (sel_onehot),
        .y_reg      (y_reg),
        .y_valid    (y_valid)
`ifdef MUX_4TO1_PARITY_EN
        ,
        .y_parity   (y_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Registered-path check; parity for WIDTH=1 equals the captured bit.
    task automatic chk_reg(input string name, input logic exp_y, input logic exp_v);
        chk({name, ".y_reg"},   32'(y_reg),   32'(exp_y));
        chk({name, ".y_valid"}, 32'(y_valid), 32'(exp_v));
`ifdef MUX_4TO1_PARITY_EN
        chk({name, ".y_parity"}, 32'(y_parity), 32'(exp_y));
`endif
    endtask

    typedef struct {
        logic [3:0] i;
        logic [1:0] s;
        logic       exp_y;
        logic [3:0] exp_oh;
    } vec_t;

    vec_t vecs [17];

    initial begin
        logic [3:0] iv;

        vecs[0]  = '{4'b0000, 2'd0, 1'b0, 4'b0001};
        vecs[1]  = '{4'b0001, 2'd0, 1'b1, 4'b0001};
        vecs[2]  = '{4'b0010, 2'd1, 1'b1, 4'b0010};
        vecs[3]  = '{4'b0100, 2'd2, 1'b1, 4'b0100};
        vecs[4]  = '{4'b1000, 2'd3, 1'b1, 4'b1000};
        vecs[5]  = '{4'b1010, 2'd0, 1'b0, 4'b0001};
        vecs[6]  = '{4'b1010, 2'd1, 1'b1, 4'b0010};
        vecs[7]  = '{4'b1010, 2'd2, 1'b0, 4'b0100};
        vecs[8]  = '{4'b1010, 2'd3, 1'b1, 4'b1000};
        vecs[9]  = '{4'b1111, 2'd0, 1'b1, 4'b0001};
        vecs[10] = '{4'b1111, 2'd1, 1'b1, 4'b0010};
        vecs[11] = '{4'b1111, 2'd2, 1'b1, 4'b0100};
        vecs[12] = '{4'b1111, 2'd3, 1'b1, 4'b1000};
        vecs[13] = '{4'b0000, 2'd0, 1'b0, 4'b0001};
        vecs[14] = '{4'b0000, 2'd1, 1'b0, 4'b0010};
        vecs[15] = '{4'b0000, 2'd2, 1'b0, 4'b0100};
        vecs[16] = '{4'b0000, 2'd3, 1'b0, 4'b1000};

        // Reset state, with the combinational path live during reset
        rst_n    = 1'b0;
        in_valid = 1'b0;
        I        = 4'b0000;
        S        = 2'd0;
        #2;
        chk_reg("reset", 1'b0, 1'b0);
        I = 4'b0001;
        #1;
        chk("reset_y_live", 32'(Y), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Combinational table
        foreach (vecs[n]) begin
            @(negedge clk);
            I = vecs[n].i;
            S = vecs[n].s;
            #1;
            chk($sformatf("comb%0d.Y", n), 32'(Y), 32'(vecs[n].exp_y));
            chk($sformatf("comb%0d.onehot", n), 32'(sel_onehot), 32'(vecs[n].exp_oh));
        end

        // Registered follow of I=1010 across all selects, one clock late
        iv = 4'b1010;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            I        = iv;
            S        = 2'(s);
            in_valid = 1'b1;
            #1;
            chk($sformatf("pre_edge%0d.y_valid", s), 32'(y_valid), (s == 0) ? 32'd0 : 32'd1);
            @(posedge clk);
            #1;
            chk_reg($sformatf("cap1010_s%0d", s), iv[s], 1'b1);
        end

        // Hold: capture 1, then drop in_valid with I cleared
        @(negedge clk);
        I = 4'b0010; S = 2'd1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk_reg("hold_cap", 1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        I        = 4'b0000;
        #1;
        chk("hold_y_now", 32'(Y), 32'd0);
        chk_reg("hold_between", 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk_reg("hold_after", 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk_reg("hold_after2", 1'b1, 1'b0);

        // Async reset between edges, capture pending at the next edge is lost
        @(negedge clk);
        I = 4'b1000; S = 2'd3; in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk_reg("pre_rst_cap", 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reg("async_rst", 1'b0, 1'b0);
        I = 4'b0001; S = 2'd0;
        #1;
        chk("rst_y_track", 32'(Y), 32'd1);
        chk("rst_onehot", 32'(sel_onehot), 32'd1);
        @(posedge clk);
        #1;
        chk_reg("rst_edge_discard", 1'b0, 1'b0);

        // Release with a pending capture
        @(negedge clk);
        I = 4'b1000; S = 2'd3; in_valid = 1'b1;
        rst_n = 1'b1;
        #1;
        chk_reg("release_pre_edge", 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_reg("release_cap", 1'b1, 1'b1);

        // Capture a zero lane so y_reg must fall
        @(negedge clk);
        S = 2'd0;
        @(posedge clk);
        #1;
        chk_reg("cap_zero", 1'b0, 1'b1);

        @(negedge clk);
        in_valid = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_4to1.md
Name: mux_4to1

Overview:
Four-input, one-output selector with a 2-bit select. Exposes a zero-latency combinational output and a one-cycle registered copy with a valid flag. Used as a generic lane selector in datapaths that need either the immediate selection or a timing-clean registered version.

Parameters:
WIDTH, 1, bit width of each input lane and of the outputs.

Ports:
clk  input  1  rising-edge clock for the registered path.
rst_n  input  1  reset, asynchronous, active-low; clears the registered path.
I  input  4*WIDTH  packed inputs; lane k occupies I[k*WIDTH +: WIDTH], lane 0 at the LSBs.
S  input  2  select; value k chooses lane k.
in_valid  input  1  qualifies I/S for capture into the register.
Y  output  WIDTH  combinational selected lane.
sel_onehot  output  4  combinational one-hot decode of S (bit k set when S==k).
y_reg  output  WIDTH  registered selected lane.
y_valid  output  1  registered in_valid.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Y = lane S of I; purely combinational, zero latency, independent of clk/rst_n.
- S=00 -> I lane 0, 01 -> lane 1, 10 -> lane 2, 11 -> lane 3 (WIDTH=1: Y = I[S]).
- sel_onehot = 4'b0001 << S; always exactly one bit set for known S.
- Register path, rising clk edge:
  - in_valid=1: y_reg <= Y; y_valid <= 1.
  - in_valid=0: y_reg holds its value; y_valid <= 0.
- Latency of register path: exactly 1 clk; y_reg/y_valid never change between edges except on reset.
- Reset: rst_n low immediately forces y_reg=0 and y_valid=0, regardless of clk. Values hold while low. Combinational Y and sel_onehot remain live during reset.
- Reset mid-operation: a capture pending at the same edge as reset assertion is discarded. First capture after reset occurs on the first rising edge with rst_n=1 and in_valid=1.
- Simultaneous change of I and S: Y reflects the new pair after settling. Glitch freedom is not required.
- No internal state other than y_reg, y_valid (and the optional parity bit).

Optional Feature:
MUX_4TO1_PARITY_EN
- Defined: adds output y_parity (1 bit) = XOR-reduction of the value captured into y_reg. It is updated under the same in_valid rule, held otherwise, and reset to 0 with rst_n.
- Undefined: y_parity port and its logic are absent. All other behaviour is identical.

Test Plan:
- WIDTH=1, sweep: I=0000,S=00 -> Y=0; I=0001,S=00 -> Y=1; I=0010,S=01 -> Y=1; I=0100,S=10 -> Y=1; I=1000,S=11 -> Y=1. sel_onehot = 0001, 0001, 0010, 0100, 1000 respectively.
- I=1010 held, S=00,01,10,11 -> Y=0,1,0,1. With in_valid=1, y_reg follows the same sequence one clk later and y_valid=1.
- I=1111, S=00..11 -> Y=1 for all selects. I=0000 for all selects -> Y=0.
- Hold: capture I=0010,S=01 (y_reg=1), then drop in_valid and set I=0000 -> y_reg stays 1, y_valid=0 next edge, Y=0 immediately.
- Async reset: with y_reg=1,y_valid=1, pull rst_n low between edges -> y_reg=0,y_valid=0 at once, and Y still tracks I/S. Release rst_n with in_valid=1,I=1000,S=11 -> y_reg=1 after first edge.
- With MUX_4TO1_PARITY_EN, WIDTH=4: capture lane value 4'b1011 -> y_parity=1. Capture 4'b1001 -> y_parity=0. Reset clears y_parity to 0.
